// File: rtl/seq_booth_mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared types and helpers for the sequential radix-4 Booth multiplier.
//   state_t       : controller states (IDLE / CALC / DONE)
//   booth_digit_t : recoded radix-4 digit selected from a multiplier triplet
//   booth_iter()  : number of Booth steps for a given operand width
// ---------------------------------------------------------------------------
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_t;

    // Operands are extended to width+2 bits so unsigned values stay positive
    // when read as two's complement; radix-4 recoding consumes 2 bits per step.
    function automatic int booth_iter(input int width);
        return (width + 2) / 2;
    endfunction

endpackage

// File: rtl/seq_booth_mult_if.sv
// ---------------------------------------------------------------------------
// seq_booth_mult_if
// Operand / product handshake bundle of seq_booth_mult.
//   in_valid/in_ready   : operand transfer when both high on a rising edge
//   a, b, signed_mode   : multiplicand, multiplier, 1 = two's complement
//   out_valid/out_ready : product transfer when both high on a rising edge
//   c                   : 2*WIDTH-bit product, held while out_valid is high
//   busy                : a product is being computed or waiting for handoff
// Handshake rule: a transfer happens on every rising edge where valid and
// ready are both high; the sender holds its payload stable while valid is
// high and ready is low.
//   master : drives operands and out_ready (upstream/downstream side)
//   slave  : the multiplier itself
// ---------------------------------------------------------------------------
interface seq_booth_mult_if #(
    parameter int WIDTH = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 signed_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   c;
    logic                 busy;

    modport master (
        output in_valid, a, b, signed_mode, out_ready,
        input  in_ready, out_valid, c, busy
    );

    modport slave (
        input  in_valid, a, b, signed_mode, out_ready,
        output in_ready, out_valid, c, busy
    );
endinterface

// File: rtl/seq_booth_mult_enc.sv
// ---------------------------------------------------------------------------
// booth_r4_enc
// Combinational radix-4 Booth encoder.
//   trip  : multiplier triplet {b[2i+1], b[2i], b[2i-1]}
//   a_ext : multiplicand already extended to WIDTH+2 bits (two's complement)
//   pp    : partial product 0, +-A or +-2A as a WIDTH+3-bit signed value
// ---------------------------------------------------------------------------
module booth_r4_enc
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       trip,
    input  logic [WIDTH+1:0] a_ext,
    output logic [WIDTH+2:0] pp
);
    booth_digit_t     digit;
    logic [WIDTH+2:0] a_x1;
    logic [WIDTH+2:0] a_x2;

    // One extra bit of headroom so +-2A is representable.
    assign a_x1 = {a_ext[WIDTH+1], a_ext};
    assign a_x2 = {a_ext, 1'b0};

    always_comb begin
        digit = ZERO;
        case (trip)
            3'b001, 3'b010: digit = POS1;
            3'b011:         digit = POS2;
            3'b100:         digit = NEG2;
            3'b101, 3'b110: digit = NEG1;
            default:        digit = ZERO;
        endcase
    end

    always_comb begin
        pp = '0;
        case (digit)
            POS1:    pp = a_x1;
            POS2:    pp = a_x2;
            NEG1:    pp = -a_x1;
            NEG2:    pp = -a_x2;
            default: pp = '0;
        endcase
    end
endmodule

// File: rtl/seq_booth_mult.sv
// ---------------------------------------------------------------------------
// seq_booth_mult
// Iterative radix-4 Booth multiplier, one Booth step per clock.
//   clk       : rising-edge clock
//   rst_n     : synchronous active-low reset
//   bus       : seq_booth_mult_if slave (operands in, product out, busy)
//   state_dbg : current controller state
// Latency from acceptance to out_valid is ITER cycles; the minimum initiation
// interval is ITER+2 (ITER steps, one DONE cycle, one IDLE cycle).
// ---------------------------------------------------------------------------
module seq_booth_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    seq_booth_mult_if.slave   bus,
    output state_t            state_dbg
);
    localparam int ITER = booth_iter(WIDTH);
    localparam int CW   = $clog2(ITER + 1);
    localparam int AW   = 2*WIDTH + 4;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH+1:0]   a_ext_q;
    logic [WIDTH+2:0]   m_q;       // {extended multiplier, b[-1]}, shifts right 2 per step
    logic [AW-1:0]      acc_q;
    logic [2*WIDTH-1:0] c_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;

    logic [WIDTH+2:0]   pp;
    logic [CW-1:0]      step;
    logic [AW-1:0]      pp_sext;
    logic [AW-1:0]      pp_shift;
    logic [AW-1:0]      acc_next;
    logic [WIDTH+1:0]   a_in_ext;
    logic [WIDTH+1:0]   b_in_ext;

    booth_r4_enc #(.WIDTH(WIDTH)) u_enc (
        .trip  (m_q[2:0]),
        .a_ext (a_ext_q),
        .pp    (pp)
    );

    // Step index i counts up from 0 while cnt counts down from ITER.
    assign step     = CW'(ITER) - cnt;
    assign pp_sext  = {{(AW-WIDTH-3){pp[WIDTH+2]}}, pp};
    assign pp_shift = pp_sext << {step, 1'b0};
    assign acc_next = acc_q + pp_shift;

    assign a_in_ext = bus.signed_mode ? {{2{bus.a[WIDTH-1]}}, bus.a} : {2'b00, bus.a};
    assign b_in_ext = bus.signed_mode ? {{2{bus.b[WIDTH-1]}}, bus.b} : {2'b00, bus.b};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            a_ext_q     <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            c_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (bus.in_valid && in_ready_q) begin
                        a_ext_q    <= a_in_ext;
                        m_q        <= {b_in_ext, 1'b0};
                        acc_q      <= '0;
                        cnt        <= CW'(ITER);
                        state      <= CALC;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                CALC: begin
                    acc_q <= acc_next;
                    m_q   <= m_q >> 2;
                    cnt   <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state       <= DONE;
                        out_valid_q <= 1'b1;
                        c_q         <= acc_next[2*WIDTH-1:0];
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.c         = c_q;
    assign state_dbg     = state;
endmodule

// File: tb/tb_seq_booth_mult.sv
// ---------------------------------------------------------------------------
// tb_seq_booth_mult
// Self-checking bench for seq_booth_mult at WIDTH = 8, 16 and 32.
// Expected products come from plain 64-bit multiplication of the extended
// operands, truncated to 2*WIDTH bits.
// ---------------------------------------------------------------------------
module tb_seq_booth_mult;
    import mult_pkg::*;

    logic   clk;
    logic   rst_n;
    state_t st8, st16, st32;
    int     n_tests;
    int     n_fail;

    seq_booth_mult_if #(.WIDTH(8))  if8  ();
    seq_booth_mult_if #(.WIDTH(16)) if16 ();
    seq_booth_mult_if #(.WIDTH(32)) if32 ();

    seq_booth_mult #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8),  .state_dbg(st8));
    seq_booth_mult #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16), .state_dbg(st16));
    seq_booth_mult #(.WIDTH(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(if32), .state_dbg(st32));

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver helpers ----------------
    task automatic drive(input int w, input logic v, input logic [31:0] av,
                         input logic [31:0] bv, input logic m);
        case (w)
            8: begin
                if8.in_valid = v; if8.a = av[7:0]; if8.b = bv[7:0]; if8.signed_mode = m;
            end
            16: begin
                if16.in_valid = v; if16.a = av[15:0]; if16.b = bv[15:0]; if16.signed_mode = m;
            end
            default: begin
                if32.in_valid = v; if32.a = av; if32.b = bv; if32.signed_mode = m;
            end
        endcase
    endtask

    task automatic set_ordy(input int w, input logic r);
        case (w)
            8:       if8.out_ready  = r;
            16:      if16.out_ready = r;
            default: if32.out_ready = r;
        endcase
    endtask

    function automatic logic [63:0] get_c(input int w);
        case (w)
            8:       return 64'(if8.c);
            16:      return 64'(if16.c);
            default: return 64'(if32.c);
        endcase
    endfunction

    function automatic logic get_ov(input int w);
        case (w)
            8:       return if8.out_valid;
            16:      return if16.out_valid;
            default: return if32.out_valid;
        endcase
    endfunction

    function automatic logic get_ir(input int w);
        case (w)
            8:       return if8.in_ready;
            16:      return if16.in_ready;
            default: return if32.in_ready;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            8:       return if8.busy;
            16:      return if16.busy;
            default: return if32.busy;
        endcase
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [63:0] ref_prod(input int w, input logic [31:0] av,
                                             input logic [31:0] bv, input logic m);
        logic [63:0] lo_mask;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] p;
        lo_mask = (64'd1 << w) - 64'd1;
        x = 64'(av) & lo_mask;
        y = 64'(bv) & lo_mask;
        if (m && x[w-1]) x = x | ~lo_mask;
        if (m && y[w-1]) y = y | ~lo_mask;
        p = x * y;
        if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
        return p;
    endfunction

    // ---------------- scoreboard check ----------------
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction, entered and left at a negedge with the DUT in IDLE.
    // hold = number of DONE cycles with out_ready low before handoff.
    task automatic txn(input int w, input logic [31:0] av, input logic [31:0] bv,
                       input logic m, input logic [63:0] exp, input string tag,
                       input int hold);
        int iter;
        int cnt;
        iter = (w + 2) / 2;
        check({tag, "_in_ready"}, 64'(get_ir(w)), 64'd1);
        drive(w, 1'b1, av, bv, m);
        set_ordy(w, hold == 0);
        @(negedge clk);
        // Operands change after acceptance; in_valid stays high and must be ignored.
        drive(w, 1'b1, ~av, ~bv, ~m);
        check({tag, "_busy"}, 64'(get_busy(w)), 64'd1);
        cnt = 0;
        while (!get_ov(w) && cnt < iter + 20) begin
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, 64'(cnt), 64'(iter));
        check({tag, "_c"}, get_c(w), exp);
        check({tag, "_in_ready_done"}, 64'(get_ir(w)), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check({tag, "_hold_c"}, get_c(w), exp);
            check({tag, "_hold_ov"}, 64'(get_ov(w)), 64'd1);
            check({tag, "_hold_in_ready"}, 64'(get_ir(w)), 64'd0);
        end
        set_ordy(w, 1'b1);
        @(negedge clk);
        check({tag, "_ov_drop"}, 64'(get_ov(w)), 64'd0);
        check({tag, "_c_kept"}, get_c(w), exp);
        drive(w, 1'b0, av, bv, m);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rm;
        int          wl[3];
        int          cnt;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wl[i] = 8 << i;
            drive(wl[i], 1'b0, 32'd0, 32'd0, 1'b0);
            set_ordy(wl[i], 1'b0);
        end

        // Reset values
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("rst_ov", 64'(get_ov(wl[i])), 64'd0);
            check("rst_busy", 64'(get_busy(wl[i])), 64'd0);
            check("rst_c", get_c(wl[i]), 64'd0);
            check("rst_in_ready", 64'(get_ir(wl[i])), 64'd0);
        end
        check("rst_state", 64'(st16), 64'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 64'(get_ir(16)), 64'd1);

        // Directed WIDTH=16 products
        txn(16, 32'h0004, 32'h0006, 1'b0, 64'h0000_0018, "u4x6", 0);
        txn(16, 32'h004C, 32'h0018, 1'b0, 64'h0000_0720, "u4Cx18", 0);
        txn(16, 32'h2CEC, 32'hCEEC, 1'b0, 64'h244F_5190, "u2CEC", 0);
        txn(16, 32'h2CEC, 32'hCEEC, 1'b1, 64'hF763_5190, "s2CEC", 0);
        txn(16, 32'h8000, 32'h8000, 1'b1, 64'h4000_0000, "s8000sq", 0);
        txn(16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE_0001, "uFFFFsq", 0);
        txn(16, 32'hFFFF, 32'h0001, 1'b1, 64'hFFFF_FFFF, "sm1x1", 0);

        // Backpressure: 5 DONE cycles with out_ready low
        txn(16, 32'h1234, 32'h5678, 1'b0, 64'h0626_0060, "bp", 5);

        // Reset in the middle of CALC (asserted so the step-4 edge resets)
        drive(16, 1'b1, 32'h7FFF, 32'h7FFF, 1'b1);
        set_ordy(16, 1'b1);
        @(negedge clk);
        drive(16, 1'b0, 32'h0, 32'h0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_ov", 64'(get_ov(16)), 64'd0);
        check("midrst_busy", 64'(get_busy(16)), 64'd0);
        check("midrst_c", get_c(16), 64'd0);
        check("midrst_in_ready", 64'(get_ir(16)), 64'd0);
        check("midrst_state", 64'(st16), 64'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (get_ov(16)) cnt++;
        end
        check("midrst_no_ov", 64'(cnt), 64'd0);
        txn(16, 32'h0003, 32'hFFFD, 1'b1, 64'h0000_0000_FFFF_FFF7, "after_rst", 0);

        // Random back-to-back products at each width
        for (int i = 0; i < 3; i++) begin
            set_ordy(wl[i], 1'b1);
            for (int n = 0; n < 1000; n++) begin
                ra = $urandom;
                rb = $urandom;
                rm = 1'($urandom_range(0, 1));
                txn(wl[i], ra, rb, rm, ref_prod(wl[i], ra, rb, rm), "rand", 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_booth_mult.md
# seq_booth_mult

Parametrised, iterative radix-4 Booth multiplier. It is the sequential successor to the 16-bit combinational `pm16` multiplier. It multiplies two WIDTH-bit operands, signed or unsigned selectable per transaction, and returns a 2·WIDTH-bit product. Operands enter and the product leaves over valid/ready handshakes. It sits in the datapath wherever a `pm16`-class product is needed and multi-cycle latency buys area.

## Interface
- `WIDTH`, default 16: operand width; must be even and ≥ 4.
- `ITER`, derived localparam = (WIDTH+2)/2: Booth steps per product (9 for WIDTH=16).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  operands valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  multiplicand.
- `b`  in  WIDTH  multiplier.
- `signed_mode`  in  1  1 = two's-complement operands; 0 = unsigned.
- `out_valid`  out  1  product valid.
- `out_ready`  in  1  downstream accepts product.
- `c`  out  2·WIDTH  product.
- `busy`  out  1  high in CALC or DONE.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid && in_ready`: capture `a`, `b`, `signed_mode`.
  - Extend both operands to WIDTH+2 bits: sign-extend if `signed_mode`, else zero-extend.
  - Clear the accumulator, set step counter = ITER, go to CALC.
- **CALC**
  - One Booth step per cycle. Examine multiplier triplet {b[2i+1], b[2i], b[2i-1]}, with b[-1]=0.
  - Select a partial product of 0, ±A or ±2A.
  - Add it, sign-extended, into the accumulator at weight 4^i.
  - Decrement the counter. After step ITER−1 (the last), go to DONE.
- **DONE**
  - `out_valid`=1; `c` = low 2·WIDTH bits of the accumulator, held stable.
  - On `out_valid && out_ready`, go to IDLE.
  - Operands are not accepted in the same cycle as result handoff.
- Arithmetic rules:
  - The accumulator is 2·WIDTH+4 bits, two's complement.
  - The result is exact modulo 2^(2·WIDTH) for all operand pairs in both modes.
- Boundary behaviour:
  - `in_valid` while in CALC or DONE is ignored; `in_ready`=0 there.
  - Operand or `signed_mode` changes after acceptance have no effect on the in-flight product.
  - `out_ready` held high in DONE: handoff on the first DONE cycle.
  - `out_ready` low: DONE persists indefinitely with `c` stable.
  - Reset at any point, including mid-CALC: the product is discarded and no `out_valid` pulse is produced.

## Timing
- Values while `rst_n`=0 and after the reset edge:
  - state = IDLE
  - `out_valid`=0, `busy`=0, `c`=0
  - `in_ready`=0 while `rst_n` is low; 1 from the first cycle after release.
- Acceptance edge = E0. Booth steps occur on edges E1…E_ITER.
- `out_valid` rises after edge E_ITER: ITER cycles of latency (9 at WIDTH=16).
- Minimum initiation interval is ITER+2 cycles:
  - ITER compute cycles,
  - 1 DONE cycle,
  - 1 IDLE cycle.
- `c` changes only on the edge entering DONE. Between transactions it keeps its last value.
- `in_ready`, `out_valid` and `busy` decode directly from the state register; there is no combinational path from `in_valid` or `out_ready` to them.

## Structure
- Package `mult_pkg` contains:
  - the state enum typedef (IDLE/CALC/DONE);
  - the Booth digit typedef (ZERO, POS1, POS2, NEG1, NEG2);
  - function `booth_iter(width)` returning (width+2)/2.
- One sub-module, `booth_r4_enc`:
  - combinational;
  - takes the 3-bit triplet and the extended multiplicand;
  - outputs the partial product, WIDTH+3 bits, sign-correct.
- The top module holds the FSM, counter, shifting multiplier register and accumulator.

## Test plan
- Unsigned, WIDTH=16:
  - a=0x0004, b=0x0006 → c=0x00000018.
  - a=0x004C, b=0x0018 → c=0x00000720.
  - Each has `out_valid` exactly 9 cycles after acceptance.
- a=0x2CEC, b=0xCEEC:
  - unsigned → 0x244F5190;
  - signed → 0xF7635190.
- Corner operands:
  - signed 0x8000×0x8000 → 0x40000000;
  - unsigned 0xFFFF×0xFFFF → 0xFFFE0001;
  - signed 0xFFFF×0x0001 → 0xFFFFFFFF.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → `c` stable, `in_ready`=0.
  - Change operands while busy → result unaffected.
- Reset:
  - Assert `rst_n`=0 at step 4 of CALC → no `out_valid`, all outputs 0.
  - The next transaction completes correctly.
- Random:
  - 1000 random pairs in both modes at WIDTH=8, 16 and 32, checked against a reference product.
  - Back-to-back transactions at an interval of ITER+2 cycles.
